// File: rtl/vga_tile_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_tile_scanner_if
//  Description : Tile-map memory read port used by vga_tile_scanner.
//                The scanner (master) presents a word address and the memory
//                (slave) returns the addressed tile word a fixed number of
//                clocks later.
//  Signals     : vga_addr  16  word address, driven by the master
//                q         16  tile word, driven by the slave
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_tile_scanner_if;
    logic [15:0] vga_addr;
    logic [15:0] q;

    modport master (output vga_addr, input q);
    modport slave  (input vga_addr, output q);
endinterface
`default_nettype wire

// File: rtl/vga_tile_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : vga_tile_scanner
//  Description : VGA timing generator with a scrolling tile-map fetch.
//                A free-running x/y raster counter produces sync, active and
//                border flags. For active pixels the tile-map word address is
//                computed and registered; the returned tile word becomes the
//                pixel colour. All outputs are delayed so they lag the raster
//                counter by exactly MEM_LATENCY+2 clocks.
//  Ports       : clock         in   pixel clock
//                reset         in   asynchronous active-high reset
//                mem           if   tile memory port (vga_addr out, q in)
//                scroll_col    in   8   horizontal tile offset
//                scroll_row    in   8   vertical tile offset
//                border_en     in   1   enable border ring
//                border_color  in   12  border RGB444
//                HS, VS        out  1   horizontal / vertical sync
//                VGA_R/G/B     out  4   pixel colour
//                frame_start   out  1   one-clock pulse per frame
//  Revision    : 1.0  initial release
// ============================================================================
module vga_tile_scanner #(
    parameter int          H_ACTIVE    = 640,
    parameter int          H_FP        = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BP        = 48,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_FP        = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BP        = 33,
    parameter int          TILE_SHIFT  = 4,
    parameter int          MEM_LATENCY = 1,     // legal range 1..4
    parameter bit          SYNC_POL    = 1'b0,  // 0: active-low sync
    parameter logic [15:0] VGA_REGION  = 16'h2000
) (
    input  logic                   clock,
    input  logic                   reset,
    vga_tile_scanner_if.master     mem,
    input  logic [7:0]             scroll_col,
    input  logic [7:0]             scroll_row,
    input  logic                   border_en,
    input  logic [11:0]            border_color,
    output logic                   HS,
    output logic                   VS,
    output logic [3:0]             VGA_R,
    output logic [3:0]             VGA_G,
    output logic [3:0]             VGA_B,
    output logic                   frame_start
);

    // ------------------------------------------------------------------------
    // Raster geometry, all held as 16-bit values to match the counters.
    // ------------------------------------------------------------------------
    localparam int          c_h_total_i = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int          c_v_total_i = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [15:0] c_h_last    = 16'(c_h_total_i - 1);
    localparam logic [15:0] c_v_last    = 16'(c_v_total_i - 1);
    localparam logic [15:0] c_h_sync    = 16'(H_SYNC);
    localparam logic [15:0] c_v_sync    = 16'(V_SYNC);
    localparam logic [15:0] c_h_start   = 16'(H_SYNC + H_BP);
    localparam logic [15:0] c_v_start   = 16'(V_SYNC + V_BP);
    localparam logic [15:0] c_h_end     = 16'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [15:0] c_v_end     = 16'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [15:0] c_px_last   = 16'(H_ACTIVE - 1);
    localparam logic [15:0] c_py_last   = 16'(V_ACTIVE - 1);
    localparam logic [15:0] c_cols      = 16'(H_ACTIVE >> TILE_SHIFT);
    localparam logic [15:0] c_rows      = 16'(V_ACTIVE >> TILE_SHIFT);

    // Flag pipeline depth: one stage for the address register, MEM_LATENCY
    // stages for the memory, one stage for the colour register.
    localparam int          c_depth     = MEM_LATENCY + 2;

    typedef struct packed {
        logic frame;
        logic border;
        logic active;
        logic vs;
        logic hs;
    } flags_t;

    localparam flags_t c_flags_rst = '{
        frame  : 1'b0,
        border : 1'b0,
        active : 1'b0,
        vs     : ~SYNC_POL,
        hs     : ~SYNC_POL
    };

    // ------------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------------
    logic [15:0] r_x;
    logic [15:0] r_y;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x <= 16'd0;
            r_y <= 16'd0;
        end else if (r_x == c_h_last) begin
            r_x <= 16'd0;
            r_y <= (r_y == c_v_last) ? 16'd0 : r_y + 16'd1;
        end else begin
            r_x <= r_x + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Scroll shadow registers. They only change at the frame origin so the
    // picture never tears when the scroll inputs move mid-frame. Storing the
    // offsets already reduced modulo the map size keeps the per-pixel wrap a
    // single conditional subtract.
    // ------------------------------------------------------------------------
    logic        w_frame_origin;
    logic [15:0] w_scol_mod;
    logic [15:0] w_srow_mod;
    logic [15:0] r_scol;
    logic [15:0] r_srow;

    assign w_frame_origin = (r_x == 16'd0) && (r_y == 16'd0);
    assign w_scol_mod     = {8'h00, scroll_col} % c_cols;
    assign w_srow_mod     = {8'h00, scroll_row} % c_rows;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scol <= 16'd0;
            r_srow <= 16'd0;
        end else if (w_frame_origin) begin
            r_scol <= w_scol_mod;
            r_srow <= w_srow_mod;
        end
    end

    // ------------------------------------------------------------------------
    // Counter-stage decode
    // ------------------------------------------------------------------------
    logic [15:0] w_px;
    logic [15:0] w_py;
    logic        w_active;
    logic        w_border;
    logic [15:0] w_tc_sum;
    logic [15:0] w_tr_sum;
    logic [15:0] w_tc;
    logic [15:0] w_tr;
    logic [15:0] w_addr_next;
    flags_t      w_flags;

    assign w_px     = r_x - c_h_start;
    assign w_py     = r_y - c_v_start;
    assign w_active = (r_x >= c_h_start) && (r_x < c_h_end) &&
                      (r_y >= c_v_start) && (r_y < c_v_end);
    assign w_border = border_en && w_active &&
                      ((w_px == 16'd0) || (w_px == c_px_last) ||
                       (w_py == 16'd0) || (w_py == c_py_last));

    // Tile index plus a pre-reduced offset stays below twice the map size,
    // so one subtract completes the modulo.
    assign w_tc_sum    = (w_px >> TILE_SHIFT) + r_scol;
    assign w_tr_sum    = (w_py >> TILE_SHIFT) + r_srow;
    assign w_tc        = (w_tc_sum >= c_cols) ? w_tc_sum - c_cols : w_tc_sum;
    assign w_tr        = (w_tr_sum >= c_rows) ? w_tr_sum - c_rows : w_tr_sum;
    assign w_addr_next = VGA_REGION + (w_tr * c_cols) + w_tc;

    always_comb begin
        w_flags        = c_flags_rst;
        w_flags.frame  = w_frame_origin;
        w_flags.border = w_border;
        w_flags.active = w_active;
        w_flags.hs     = (r_x < c_h_sync) ? SYNC_POL : ~SYNC_POL;
        w_flags.vs     = (r_y < c_v_sync) ? SYNC_POL : ~SYNC_POL;
    end

    // ------------------------------------------------------------------------
    // Address register: follows the raster during active video and holds the
    // last fetched address through blanking.
    // ------------------------------------------------------------------------
    logic [15:0] r_addr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr <= VGA_REGION;
        end else if (w_active) begin
            r_addr <= w_addr_next;
        end
    end

    assign mem.vga_addr = r_addr;

    // ------------------------------------------------------------------------
    // Flag delay line. Entry k holds the counter-stage flags from k+1 clocks
    // ago; the last entry drives the sync and frame outputs directly.
    // ------------------------------------------------------------------------
    flags_t r_pipe [c_depth];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_pipe[i] <= c_flags_rst;
            end
        end else begin
            r_pipe[0] <= w_flags;
            for (int i = 1; i < c_depth; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Colour register. It loads on the same edge as the last flag stage, so
    // it selects with the flags one stage earlier, which line up with the
    // tile word currently on q.
    // ------------------------------------------------------------------------
    flags_t      w_sel;
    logic [11:0] r_rgb;
    logic        w_unused_q_hi;

    assign w_sel         = r_pipe[c_depth-2];
    assign w_unused_q_hi = ^mem.q[15:12];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rgb <= 12'h000;
        end else if (!w_sel.active) begin
            r_rgb <= 12'h000;
        end else if (w_sel.border) begin
            r_rgb <= border_color;
        end else begin
            r_rgb <= mem.q[11:0];
        end
    end

    assign HS          = r_pipe[c_depth-1].hs;
    assign VS          = r_pipe[c_depth-1].vs;
    assign frame_start = r_pipe[c_depth-1].frame;
    assign VGA_R       = r_rgb[11:8];
    assign VGA_G       = r_rgb[7:4];
    assign VGA_B       = r_rgb[3:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_tile_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_tile_scanner
//  Description : Directed self-checking bench for vga_tile_scanner, using a
//                reduced raster (160x55 clocks, 128x48 visible, 16-pixel
//                tiles -> 8x3 tile map) so several frames run quickly.
//                Cycle k is the interval after the k-th rising edge following
//                reset release; the raster counter is (0,0) in cycle 0.
//                A one-clock memory model returns vga_addr ^ 0x0A50, or the
//                constant 0x0ABC when mem_mode is 0.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_tile_scanner;

    logic        clock;
    logic        reset;
    logic [7:0]  scroll_col;
    logic [7:0]  scroll_row;
    logic        border_en;
    logic [11:0] border_color;
    logic        HS;
    logic        VS;
    logic [3:0]  VGA_R;
    logic [3:0]  VGA_G;
    logic [3:0]  VGA_B;
    logic        frame_start;
    logic        mem_mode;

    vga_tile_scanner_if mem_bus ();

    vga_tile_scanner #(
        .H_ACTIVE    (128),
        .H_FP        (8),
        .H_SYNC      (16),
        .H_BP        (8),
        .V_ACTIVE    (48),
        .V_FP        (2),
        .V_SYNC      (2),
        .V_BP        (3),
        .TILE_SHIFT  (4),
        .MEM_LATENCY (1),
        .SYNC_POL    (1'b0),
        .VGA_REGION  (16'h2000)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mem          (mem_bus.master),
        .scroll_col   (scroll_col),
        .scroll_row   (scroll_row),
        .border_en    (border_en),
        .border_color (border_color),
        .HS           (HS),
        .VS           (VS),
        .VGA_R        (VGA_R),
        .VGA_G        (VGA_G),
        .VGA_B        (VGA_B),
        .frame_start  (frame_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One-clock-latency tile memory.
    always @(posedge clock) begin
        mem_bus.q <= mem_mode ? (mem_bus.vga_addr ^ 16'h0A50) : 16'h0ABC;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Waveform statistics gathered every cycle.
    logic prev_hs, prev_vs;
    int   hs_fall, hs_period, hs_run, hs_low;
    int   vs_fall, vs_period, vs_run, vs_low;
    int   fs_count, fs_first, fs_misalign;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        prev_hs     = 1'b1;
        prev_vs     = 1'b1;
        hs_fall     = -1;
        hs_period   = 0;
        hs_run      = 0;
        hs_low      = 0;
        vs_fall     = -1;
        vs_period   = 0;
        vs_run      = 0;
        vs_low      = 0;
        fs_count    = 0;
        fs_first    = -1;
        fs_misalign = 0;
    endtask

    task automatic step();
        logic vs_fell;
        @(posedge clock);
        cyc++;
        @(negedge clock);
        if (prev_hs && !HS) begin
            if (hs_fall >= 0) hs_period = cyc - hs_fall;
            hs_fall = cyc;
        end
        if (!HS) hs_run++;
        else if (!prev_hs) begin
            hs_low = hs_run;
            hs_run = 0;
        end
        vs_fell = prev_vs && !VS;
        if (vs_fell) begin
            if (vs_fall >= 0) vs_period = cyc - vs_fall;
            vs_fall = cyc;
        end
        if (!VS) vs_run++;
        else if (!prev_vs) begin
            vs_low = vs_run;
            vs_run = 0;
        end
        if (frame_start === 1'b1) begin
            fs_count++;
            if (fs_first < 0) fs_first = cyc;
        end
        if (frame_start !== vs_fell) fs_misalign++;
        prev_hs = HS;
        prev_vs = VS;
    endtask

    task automatic goto(input int k);
        while (cyc < k) step();
    endtask

    function automatic logic [11:0] rgb();
        return {VGA_R, VGA_G, VGA_B};
    endfunction

    task automatic check_stats(input string pfx);
        check({pfx, "_hs_period"},   hs_period,   160);
        check({pfx, "_hs_low"},      hs_low,      16);
        check({pfx, "_vs_period"},   vs_period,   8800);
        check({pfx, "_vs_low"},      vs_low,      320);
        check({pfx, "_fs_count"},    fs_count,    2);
        check({pfx, "_fs_first"},    fs_first,    3);
        check({pfx, "_fs_misalign"}, fs_misalign, 0);
    endtask

    initial begin
        reset        = 1'b1;
        scroll_col   = 8'd0;
        scroll_row   = 8'd0;
        border_en    = 1'b0;
        border_color = 12'h000;
        mem_mode     = 1'b0;
        clear_stats();

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_addr", mem_bus.vga_addr, 16'h2000);
        check("rst_hs",   HS,               1'b1);
        check("rst_vs",   VS,               1'b1);
        check("rst_rgb",  rgb(),            12'h000);
        check("rst_fs",   frame_start,      1'b0);

        reset = 1'b0;
        cyc   = 0;
        clear_stats();

        // Frame 0: no scroll, no border, constant q = 0x0ABC
        goto(825);   check("addr_0_0",       mem_bus.vga_addr, 16'h2000);
        goto(826);   check("rgb_bp_blank",   rgb(),            12'h000);
        goto(827);   check("rgb_first_px",   rgb(),            12'hABC);
        goto(841);   check("addr_16_0",      mem_bus.vga_addr, 16'h2001);
        goto(954);   check("rgb_last_px",    rgb(),            12'hABC);
        goto(955);   check("rgb_fp_blank",   rgb(),            12'h000);
        goto(3385);  check("addr_0_16",      mem_bus.vga_addr, 16'h2008);
        goto(4000);
        scroll_col = 8'd15;   // reduces to 7 of 8 columns
        scroll_row = 8'd4;    // reduces to 1 of 3 rows
        goto(7241);  check("addr_scroll_held", mem_bus.vga_addr, 16'h2011);
        goto(8472);  check("addr_127_47",    mem_bus.vga_addr, 16'h2017);
        goto(8473);  check("addr_hold_blank", mem_bus.vga_addr, 16'h2017);
        goto(8500);
        border_en    = 1'b1;
        border_color = 12'hF00;
        mem_mode     = 1'b1;

        // Frame 1: scroll (7,1), border on, q = addr ^ 0x0A50
        goto(9625);  check("scroll_tile0",   mem_bus.vga_addr, 16'h200F);
        goto(9641);  check("scroll_tile1",   mem_bus.vga_addr, 16'h2008);
        goto(9677);  check("border_row0",    rgb(),            12'hF00);
        goto(9755);  check("border_fp_blank", rgb(),           12'h000);
        goto(9802);  check("rgb_px15_py1",   rgb(),            12'hA5F);
        goto(9803);  check("rgb_px16_py1",   rgb(),            12'hA58);
        goto(12827); check("border_col0",    rgb(),            12'hF00);
        goto(12828); check("rgb_interior",   rgb(),            12'hA47);
        goto(12954); check("border_col127",  rgb(),            12'hF00);
        goto(14745); check("scroll_row_wrap", mem_bus.vga_addr, 16'h2007);
        goto(17207); check("border_row47",   rgb(),            12'hF00);
        goto(17600); check_stats("t1");

        // Frame 2: asynchronous reset at raster (100,30)
        goto(22500);
        check("pre_rst_addr", mem_bus.vga_addr, 16'h2013);
        check("pre_rst_rgb",  rgb(),            12'hA43);
        #2 reset = 1'b1;
        #1;
        check("async_addr", mem_bus.vga_addr, 16'h2000);
        check("async_hs",   HS,               1'b1);
        check("async_vs",   VS,               1'b1);
        check("async_rgb",  rgb(),            12'h000);
        check("async_fs",   frame_start,      1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        cyc   = 0;
        clear_stats();
        goto(17600); check_stats("t2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
